// File: rtl/arb_pkg.sv
// Shared types and default sizes for the two-requester memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_e;

  localparam int WORD_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 5;
  localparam int BURST_MAX_DEF = 4;

  // Requester index (0 = CPU, 1 = decrypt engine) to one-hot grant/ack vector.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled as one interface.
interface mem_arbiter_if
  import arb_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [1:0]        req;
  logic [1:0]        lock;
  logic [1:0]        r_nw;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [WORD_W-1:0] wdata0;
  logic [WORD_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        ack;
  logic [WORD_W-1:0] rdata;
  logic              mem_CS;
  logic              mem_R_NW;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  req, lock, r_nw, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt, ack, rdata, mem_CS, mem_R_NW, mem_addr, mem_wdata
  );

  // Requesters plus memory model side.
  modport master (
    output req, lock, r_nw, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt, ack, rdata, mem_CS, mem_R_NW, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_pick.sv
// Owner selection: locked re-grant of the last owner while the burst budget
// lasts, otherwise round-robin on a tie, otherwise the lone requester.
module arb_pick
  import arb_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int CNT_W     = 3
) (
  input  logic [1:0]       req_i,
  input  logic [1:0]       lock_i,
  input  logic             last_i,
  input  logic [CNT_W-1:0] burst_cnt_i,
  output logic             owner_o,
  output logic             relock_o
);

  // Priority: burst lock, then alternate on a tie, then whoever is asking.
  always_comb begin
    relock_o = req_i[last_i] & lock_i[last_i] &
               (burst_cnt_i < CNT_W'(BURST_MAX));
    owner_o  = last_i;
    if (relock_o) begin
      owner_o = last_i;
    end else if (&req_i) begin
      owner_o = ~last_i;
    end else begin
      owner_o = req_i[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: IDLE -> ACCESS -> ACK per access.
//
//   state  | meaning
//   IDLE   | no transaction; pick an owner and latch its request when req != 0
//   ACCESS | memory strobed with the latched transaction
//   ACK    | one-cycle ack to the owner; read data already in rdata
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  arb_state_e        state_q;
  logic              last_q;      // requester granted most recently; also current owner
  logic [CNT_W-1:0]  burst_cnt_q;
  logic              r_nw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [1:0]        gnt_q;
  logic [1:0]        ack_q;
  logic [WORD_W-1:0] rdata_q;

  logic              pick_owner;
  logic              pick_relock;

  arb_pick #(
    .BURST_MAX (BURST_MAX),
    .CNT_W     (CNT_W)
  ) u_pick (
    .req_i       (bus.req),
    .lock_i      (bus.lock),
    .last_i      (last_q),
    .burst_cnt_i (burst_cnt_q),
    .owner_o     (pick_owner),
    .relock_o    (pick_relock)
  );

  // Transaction sequencer with registered grant, ack and read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      r_nw_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (|bus.req) begin
            last_q      <= pick_owner;
            burst_cnt_q <= pick_relock ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
            r_nw_q      <= bus.r_nw[pick_owner];
            addr_q      <= pick_owner ? bus.addr1 : bus.addr0;
            wdata_q     <= pick_owner ? bus.wdata1 : bus.wdata0;
            gnt_q       <= onehot2(pick_owner);
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_nw_q) begin
            rdata_q <= bus.mem_rdata;
          end
          ack_q   <= onehot2(last_q);
          state_q <= ACK;
        end
        ACK: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory strobe is decoded from the state so it is live only in ACCESS.
  always_comb begin
    bus.mem_CS    = 1'b0;
    bus.mem_R_NW  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state_q == ACCESS) begin
      bus.mem_CS    = 1'b1;
      bus.mem_R_NW  = r_nw_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; memory model returns {addr} ^ 8'hA6,
// so address 3 reads 8'hA5 and address 5'h1F reads 8'hB9.
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  mem_arbiter_if #(.WORD_W(8), .ADDR_W(5)) bus ();

  mem_arbiter #(
    .WORD_W    (8),
    .ADDR_W    (5),
    .BURST_MAX (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mem_rdata = {3'b000, bus.mem_addr} ^ 8'hA6;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [1:0] exp_ack;
    logic [1:0] lock_seq [6];
    lock_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

    bus.req = '0; bus.lock = '0; bus.r_nw = '0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

    // reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst_gnt",   bus.gnt,      0);
    chk("rst_ack",   bus.ack,      0);
    chk("rst_rdata", bus.rdata,    0);
    chk("rst_cs",    bus.mem_CS,   0);
    chk("rst_addr",  bus.mem_addr, 0);

    // CPU read of address 3
    reset = 1'b0;
    bus.req = 2'b01; bus.r_nw = 2'b01; bus.addr0 = 5'h03; bus.addr1 = 5'h07;
    bus.wdata0 = 8'h11;
    tick();
    chk("rd_cs",    bus.mem_CS,    1);
    chk("rd_rnw",   bus.mem_R_NW,  1);
    chk("rd_addr",  bus.mem_addr,  5'h03);
    chk("rd_wdata", bus.mem_wdata, 8'h11);
    chk("rd_gnt",   bus.gnt,       2'b01);
    chk("rd_ack1",  bus.ack,       0);
    bus.addr0 = 5'h09; bus.r_nw = 2'b00;
    #1;
    chk("rd_latch_addr", bus.mem_addr, 5'h03);
    chk("rd_latch_rnw",  bus.mem_R_NW, 1);
    tick();
    chk("rd_ack",   bus.ack,    2'b01);
    chk("rd_rdata", bus.rdata,  8'hA5);
    chk("rd_cs2",   bus.mem_CS, 0);
    chk("rd_gnt2",  bus.gnt,    2'b01);
    bus.req = '0;
    tick();
    chk("rd_idle_gnt",  bus.gnt,   0);
    chk("rd_idle_ack",  bus.ack,   0);
    chk("rd_hold",      bus.rdata, 8'hA5);

    // decryptor write to 1F
    bus.req = 2'b10; bus.r_nw = 2'b00; bus.addr1 = 5'h1F; bus.wdata1 = 8'h3C;
    tick();
    chk("wr_cs",    bus.mem_CS,    1);
    chk("wr_rnw",   bus.mem_R_NW,  0);
    chk("wr_addr",  bus.mem_addr,  5'h1F);
    chk("wr_wdata", bus.mem_wdata, 8'h3C);
    chk("wr_gnt",   bus.gnt,       2'b10);
    tick();
    chk("wr_ack",   bus.ack,       2'b10);
    chk("wr_rdata", bus.rdata,     8'hA5);
    chk("wr_idle_wdata", bus.mem_wdata, 0);
    bus.req = '0;
    tick();

    // continuous tie after reset: CPU, DEC, CPU, DEC, acks 3 cycles apart
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    bus.req = 2'b11; bus.lock = 2'b00; bus.r_nw = 2'b11;
    bus.addr0 = 5'h03; bus.addr1 = 5'h1F;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_ack = 2'b00;
      if (c % 3 == 2) exp_ack = ((c / 3) % 2 != 0) ? 2'b10 : 2'b01;
      chk($sformatf("rr_ack_c%0d", c), bus.ack, exp_ack);
      if (exp_ack == 2'b01) chk($sformatf("rr_rdata_c%0d", c), bus.rdata, 8'hA5);
      if (exp_ack == 2'b10) chk($sformatf("rr_rdata_c%0d", c), bus.rdata, 8'hB9);
    end
    bus.req = '0;
    tick(); tick(); tick();

    // DEC lock: four DEC grants, then CPU, then DEC
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    bus.req = 2'b11; bus.lock = 2'b10;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("lk_gnt_%0d", k), bus.gnt, lock_seq[k]);
      tick();
      chk($sformatf("lk_ack_%0d", k), bus.ack, lock_seq[k]);
      tick();
      chk($sformatf("lk_idle_%0d", k), bus.gnt, 0);
    end
    bus.req = '0; bus.lock = '0;
    tick();

    // reset in ACCESS aborts; next tie goes to CPU
    bus.req = 2'b01; bus.r_nw = 2'b01; bus.addr0 = 5'h03;
    tick();
    chk("ab_cs", bus.mem_CS, 1);
    reset = 1'b1;
    tick();
    chk("ab_gnt",   bus.gnt,       0);
    chk("ab_ack",   bus.ack,       0);
    chk("ab_cs0",   bus.mem_CS,    0);
    chk("ab_rnw0",  bus.mem_R_NW,  0);
    chk("ab_addr0", bus.mem_addr,  0);
    chk("ab_rdata", bus.rdata,     0);
    reset = 1'b0;
    bus.req = 2'b11; bus.lock = 2'b00;
    tick();
    chk("ab_tie_gnt", bus.gnt, 2'b01);
    tick();
    chk("ab_tie_ack", bus.ack, 2'b01);
    bus.req = '0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
